clock_divider_controller: RTL

CLOCK_DIVIDER_CONTROLLER -- requirements
Module: clock_divider_controller

---
 rtl/clock_divider_controller.sv | 151 +++++++++++++++
 1 files changed

// File: rtl/clock_divider_controller.sv
// Clock divider: a registered 50% duty clock at clk_FPGA / (2 * active_half), with a
// ready/valid half-period update that switches only on a falling toggle. Optional macro CLKDIV_CFG_CHECK_EN.
module clock_divider_controller #(
    parameter int unsigned REFERENCE_CLOCK     = 50_000_000,
    parameter int unsigned NBITS_FOR_COUNTER   = 16,
    parameter int unsigned DEFAULT_HALF_PERIOD = 5
) (
    input  logic                         clk_FPGA,
    input  logic                         reset,
    input  logic                         enable,
    input  logic                         cfg_valid,
    input  logic [NBITS_FOR_COUNTER-1:0] cfg_half_period,
    output logic                         cfg_ready,
    output logic                         clock_signal,
    output logic                         tick,
    output logic                         busy
`ifdef CLKDIV_CFG_CHECK_EN
    ,
    output logic                         cfg_error
`endif
);

    localparam int unsigned W = NBITS_FOR_COUNTER;
    localparam logic [W-1:0] RESET_HALF = W'(DEFAULT_HALF_PERIOD);

    // A zero reset half-period would leave the divider without a legal compare value.
    if (DEFAULT_HALF_PERIOD == 0 || REFERENCE_CLOCK < 2 * DEFAULT_HALF_PERIOD) begin : g_bad_params
        $error("clock_divider_controller: illegal DEFAULT_HALF_PERIOD / REFERENCE_CLOCK");
    end

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        STOPPING
    } state_t;

    state_t         state;
    state_t         state_next;
    logic [W-1:0]   count;
    logic [W-1:0]   count_next;
    logic [W-1:0]   active_half;
    logic [W-1:0]   pending;
    logic           pending_valid;
    logic           ready_q;
    logic           clock_next;
    logic           tick_next;
    logic           apply;
    logic           accept;
    logic           at_toggle;

    // No transfer can complete while reset is asserted.
    assign accept    = cfg_valid && ready_q && !reset;
    assign cfg_ready = ready_q && !reset;
    assign at_toggle = (count >= active_half - W'(1));

    // Next-state, counter and divided-clock decode.
    always_comb begin
        state_next = state;
        count_next = count;
        clock_next = clock_signal;
        tick_next  = 1'b0;
        apply      = 1'b0;
        case (state)
            IDLE: begin
                count_next = '0;
                clock_next = 1'b0;
                apply      = pending_valid;
                if (enable) begin
                    state_next = RUN;
                end
            end
            RUN, STOPPING: begin
                if (at_toggle) begin
                    count_next = '0;
                    // New half-period only lands on a 1->0 toggle so the low phase uses it.
                    apply      = pending_valid && clock_signal;
                    if (enable) begin
                        state_next = RUN;
                        clock_next = !clock_signal;
                        tick_next  = !clock_signal;
                    end else begin
                        state_next = IDLE;
                        clock_next = 1'b0;
                    end
                end else begin
                    count_next = count + W'(1);
                    state_next = enable ? RUN : STOPPING;
                end
            end
            default: begin
                state_next = IDLE;
                count_next = '0;
                clock_next = 1'b0;
            end
        endcase
    end

`ifndef CLKDIV_CFG_CHECK_EN
    logic [W-1:0] cfg_value;
    assign cfg_value = (cfg_half_period == '0) ? W'(1) : cfg_half_period;
`endif

    // State, output and configuration registers.
    always_ff @(posedge clk_FPGA) begin
        if (reset) begin
            state         <= IDLE;
            count         <= '0;
            clock_signal  <= 1'b0;
            tick          <= 1'b0;
            busy          <= 1'b0;
            active_half   <= RESET_HALF;
            pending       <= '0;
            pending_valid <= 1'b0;
            ready_q       <= 1'b1;
`ifdef CLKDIV_CFG_CHECK_EN
            cfg_error     <= 1'b0;
`endif
        end else begin
            state        <= state_next;
            count        <= count_next;
            clock_signal <= clock_next;
            tick         <= tick_next;
            busy         <= (state_next != IDLE);
`ifdef CLKDIV_CFG_CHECK_EN
            cfg_error    <= 1'b0;
`endif
            if (apply) begin
                active_half   <= pending;
                pending_valid <= 1'b0;
                ready_q       <= 1'b1;
            end
            if (accept) begin
`ifdef CLKDIV_CFG_CHECK_EN
                // Zero is consumed but discarded; the window stays open.
                if (cfg_half_period == '0) begin
                    cfg_error <= 1'b1;
                end else begin
                    pending       <= cfg_half_period;
                    pending_valid <= 1'b1;
                    ready_q       <= 1'b0;
                end
`else
                pending       <= cfg_value;
                pending_valid <= 1'b1;
                ready_q       <= 1'b0;
`endif
            end
        end
    end

endmodule
